// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO pair.
// WIDTH shift steps plus one fixup cycle per op; stall holds dependent EX work while busy.
module hilo_muldiv_unit #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               sgn_a_q;
    logic               sgn_b_q;
    logic               div0_q;
    logic               done_q;
    // {upper W+1 bits, lower W bits}: partial product / running remainder on top,
    // multiplier / dividend-becoming-quotient on the bottom.
    logic [2*WIDTH:0]   acc_q;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    // Signed ops work on magnitudes; the most negative value maps to 2^(WIDTH-1).
    always_comb begin
        a_mag = src_a;
        b_mag = src_b;
        if (!op[0] && src_a[WIDTH-1]) a_mag = -src_a;
        if (!op[0] && src_b[WIDTH-1]) b_mag = -src_b;
    end

    always_comb begin
        add_sum   = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        if (!op_q[1]) begin
            acc_d = {1'b0, add_sum, acc_q[WIDTH-1:1]};
        end else if (!rem_diff[WIDTH]) begin
            acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = {rem_shift, acc_q[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_fix = (sgn_a_q ^ sgn_b_q) ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        quo_fix  = (sgn_a_q ^ sgn_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sgn_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        if (!op_q[1]) begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            hi_d = a_q;
            lo_d = DIV0_LO;
        end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            sgn_a_q <= 1'b0;
            sgn_b_q <= 1'b0;
            div0_q  <= 1'b0;
            done_q  <= 1'b0;
            acc_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        op_q    <= op;
                        a_q     <= src_a;
                        opnd_q  <= op[1] ? b_mag : a_mag;
                        acc_q   <= {{(WIDTH+1){1'b0}}, (op[1] ? a_mag : b_mag)};
                        sgn_a_q <= ~op[0] & src_a[WIDTH-1];
                        sgn_b_q <= ~op[0] & src_b[WIDTH-1];
                        div0_q  <= (src_b == '0);
                    end else begin
                        if (mthi) hi_q <= mt_data;
                        if (mtlo) lo_q <= mt_data;
                    end
                end
                S_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIN;
                end
                S_FIN: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign stall   = busy & (start | rd_req | mthi | mtlo);
    assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboarded bench for hilo_muldiv_unit: directed cases plus randomized traffic.
module tb_hilo_muldiv_unit;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        reset, start, rd_req, rd_sel, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] src_a, src_b, mt_data, rd_data;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv_unit #(.WIDTH(W), .DIV0_LO(32'hFFFFFFFF)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .mthi(mthi), .mtlo(mtlo),
        .mt_data(mt_data), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_data(rd_data), .busy(busy), .done(done), .stall(stall)
    );

    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          busy_left = 0;
    bit          done_next = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      p;
        logic [63:0] r;
        sa = a;
        sb = b;
        case (o)
            2'b00: begin p = longint'(sa) * longint'(sb); r = p; end
            2'b01: r = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'h0, 32'h80000000};
                else r = {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Monitor: cycle-level expectations for busy/done/stall/rd_data.
    always @(negedge clk) begin
        bit exp_done, exp_busy;
        if (mon_en) begin
            exp_done  = done_next;
            done_next = 1'b0;
            exp_busy  = (busy_left > 0);
            if (exp_done) begin
                chk("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) {m_hi, m_lo} = exp_q.pop_front();
            end
            chk("busy", busy, exp_busy);
            chk("done", done, exp_done);
            chk("stall", stall, exp_busy & (start | rd_req | mthi | mtlo));
            if (rd_sel) chk("rd_hi", rd_data, m_hi);
            else        chk("rd_lo", rd_data, m_lo);
            if (reset) begin
                busy_left = 0;
                done_next = 1'b0;
                m_hi = '0;
                m_lo = '0;
                exp_q.delete();
            end else if (exp_busy) begin
                busy_left--;
                if (busy_left == 0) done_next = 1'b1;
            end else if (start) begin
                exp_q.push_back(ref_op(op, src_a, src_b));
                busy_left = W + 1;
            end else begin
                if (mthi) m_hi = mt_data;
                if (mtlo) m_lo = mt_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; rd_req = 0; rd_sel = 0; mthi = 0; mtlo = 0;
        op = 0; src_a = 0; src_b = 0; mt_data = 0;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; src_a = a; src_b = b; start = 1;
        tick();
        start = 0;
    endtask

    // Returns positioned inside the done cycle.
    task automatic wait_done(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
    endtask

    task automatic read_pair(input string name, input logic [31:0] hi, input logic [31:0] lo);
        rd_sel = 0; #1; chk({name, "_lo"}, rd_data, lo);
        rd_sel = 1; #1; chk({name, "_hi"}, rd_data, hi);
        rd_sel = 0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset = 1;
        idle_inputs();
        tick();
        mon_en = 1;
        repeat (2) tick();
        reset = 0;
        read_pair("reset_state", 32'h0, 32'h0);

        mthi = 1; mt_data = 32'h12345678;
        tick();
        mthi = 0;
        read_pair("mthi_idle", 32'h12345678, 32'h0);

        // MULT -3 x 7 and busy length
        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        chk("mult_busy_cycles", n, W + 1);
        chk("mult_done_pulse", done, 1'b1);
        tick();
        read_pair("mult_neg", 32'hFFFFFFFF, 32'hFFFFFFEB);

        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done("multu_max"); tick();
        read_pair("multu_max", 32'hFFFFFFFE, 32'h00000001);

        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg"); tick();
        read_pair("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(2'b11, 32'd100, 32'd0);
        wait_done("divu_zero"); tick();
        read_pair("divu_zero", 32'd100, 32'hFFFFFFFF);

        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf"); tick();
        read_pair("div_ovf", 32'h0, 32'h80000000);

        // Hazards: MFHI held in EX, second start during busy ignored
        issue(2'b00, 32'hFFFFFFFB, 32'd6);
        rd_req = 1; rd_sel = 1;
        repeat (10) tick();
        op = 2'b01; src_a = 32'd9; src_b = 32'd9; start = 1;
        tick();
        start = 0;
        wait_done("hazard");
        chk("hazard_stall_done", stall, 1'b0);
        chk("hazard_rd_new_hi", rd_data, 32'hFFFFFFFF);
        tick();
        rd_req = 0;
        read_pair("hazard", 32'hFFFFFFFF, 32'hFFFFFFE2);

        // start + mtlo together, then mtlo while busy
        mtlo = 1; mt_data = 32'hDEADBEEF;
        issue(2'b01, 32'd2, 32'd3);
        mtlo = 0;
        rd_sel = 0; #1;
        chk("start_mtlo_dropped", rd_data, 32'hFFFFFFE2);
        mtlo = 1; mt_data = 32'hCAFEF00D; #1;
        chk("mtlo_busy_stall", stall, 1'b1);
        tick();
        mtlo = 0;
        wait_done("start_mtlo"); tick();
        read_pair("start_mtlo", 32'h0, 32'd6);

        // Reset mid-RUN
        issue(2'b00, 32'd3, 32'd3);
        repeat (10) tick();
        reset = 1;
        repeat (2) tick();
        reset = 0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        read_pair("rst_mid_run", 32'h0, 32'h0);
        repeat (40) tick();

        for (int c = 0; c < 3000; c++) begin
            reset   = ($urandom_range(0, 599) == 0);
            start   = ($urandom_range(0, 5) == 0);
            op      = 2'($urandom);
            src_a   = pick();
            src_b   = pick();
            mthi    = ($urandom_range(0, 7) == 0);
            mtlo    = ($urandom_range(0, 7) == 0);
            mt_data = $urandom;
            rd_req  = 1'($urandom);
            rd_sel  = 1'($urandom);
            tick();
        end
        reset = 0;
        idle_inputs();
        repeat (40) tick();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
